// File: rtl/last_n_history.sv
// last_n_history: registered history of the last DEPTH switch selections, newest in slot 0.
// Optional feature: define HISTORY_DEDUP_EN so that re-selecting the newest index only refreshes its status.
module last_n_history #(
    parameter int IDX_W = 6,
    parameter int NSW   = 18,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     active,
    input  logic [IDX_W-1:0]         number,
    input  logic [NSW-1:0]           switches,
    input  logic                     clear,
    output logic [DEPTH*IDX_W-1:0]   entry,
    output logic [DEPTH-1:0]         status,
    output logic [DEPTH-1:0]         valid,
    output logic [CW-1:0]            count,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

    state_t                  state_q;
    logic [DEPTH*IDX_W-1:0]  entry_q;
    logic [DEPTH-1:0]        status_q, valid_q;
    logic [CW-1:0]           count_q;
    logic                    busy_q, done_q, err_q, sw_q, dup_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    sw_d, dup_d, in_range;

    // Decode the one-based request into an index, its switch bit and the range/dedup flags.
    always_comb begin
        idx_d    = number - IDX_W'(1);
        sw_d     = |(switches & (NSW'(1) << idx_d));
        in_range = (number != '0) && (int'(number) <= NSW);
`ifdef HISTORY_DEDUP_EN
        dup_d    = valid_q[0] && (entry_q[IDX_W-1:0] == idx_d);
`else
        dup_d    = 1'b0;
`endif
    end

    // Control FSM with the history registers and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            status_q <= '0;
            valid_q  <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            sw_q     <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        entry_q  <= '0;
                        status_q <= '0;
                        valid_q  <= '0;
                        count_q  <= '0;
                    end else if (active && !in_range) begin
                        err_q <= 1'b1;
                    end else if (active) begin
                        idx_q   <= idx_d;
                        sw_q    <= sw_d;
                        dup_q   <= dup_d;
                        busy_q  <= 1'b1;
                        state_q <= dup_d ? CAPTURE : SHIFT;
                    end
                end
                SHIFT: begin
                    entry_q  <= {entry_q[(DEPTH-1)*IDX_W-1:0], {IDX_W{1'b0}}};
                    status_q <= {status_q[DEPTH-2:0], 1'b0};
                    valid_q  <= {valid_q[DEPTH-2:0], 1'b0};
                    state_q  <= CAPTURE;
                end
                CAPTURE: begin
                    entry_q[IDX_W-1:0] <= idx_q;
                    status_q[0]        <= sw_q;
                    valid_q[0]         <= 1'b1;
                    if (!dup_q && count_q != CW'(DEPTH)) count_q <= count_q + 1'b1;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign entry  = entry_q;
    assign status = status_q;
    assign valid  = valid_q;
    assign count  = count_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
endmodule

// File: tb/tb_last_n_history.sv
// tb_last_n_history: scoreboard bench for last_n_history; honours HISTORY_DEDUP_EN in its model.
module tb_last_n_history;
    localparam int IDX_W = 6;
    localparam int NSW   = 18;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [DEPTH*IDX_W-1:0] e;
        logic [DEPTH-1:0]       s;
        logic [DEPTH-1:0]       v;
        logic [CW-1:0]          c;
    } snap_t;

    logic                   clk, reset, active, clear;
    logic [IDX_W-1:0]       number;
    logic [NSW-1:0]         switches;
    logic [DEPTH*IDX_W-1:0] entry;
    logic [DEPTH-1:0]       status, valid;
    logic [CW-1:0]          count;
    logic                   busy, done, err;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    m_e[DEPTH];
    bit    m_s[DEPTH];
    bit    m_v[DEPTH];
    int    m_c;
    snap_t exp_q[$];

    last_n_history #(.IDX_W(IDX_W), .NSW(NSW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .active(active), .number(number),
        .switches(switches), .clear(clear), .entry(entry), .status(status),
        .valid(valid), .count(count), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_e[k] = 0;
            m_s[k] = 0;
            m_v[k] = 0;
        end
        m_c = 0;
    endtask

    function automatic snap_t snap();
        snap_t x;
        for (int k = 0; k < DEPTH; k++) begin
            x.e[k*IDX_W +: IDX_W] = IDX_W'(m_e[k]);
            x.s[k] = m_s[k];
            x.v[k] = m_v[k];
        end
        x.c = CW'(m_c);
        return x;
    endfunction

    task automatic cmp_snap(input string tag, input snap_t x);
        check({tag, "_entry"}, 64'(entry), 64'(x.e));
        check({tag, "_status"}, 64'(status), 64'(x.s));
        check({tag, "_valid"}, 64'(valid), 64'(x.v));
        check({tag, "_count"}, 64'(count), 64'(x.c));
    endtask

    task automatic request(input int n, input logic [NSW-1:0] s, input bit inject);
        snap_t x;
        int    lat;
        bit    dup;
        dup = 0;
`ifdef HISTORY_DEDUP_EN
        dup = m_v[0] && (m_e[0] == n - 1);
`endif
        if (dup) m_s[0] = s[n-1];
        else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_e[k] = m_e[k-1];
                m_s[k] = m_s[k-1];
                m_v[k] = m_v[k-1];
            end
            m_e[0] = n - 1;
            m_s[0] = s[n-1];
            m_v[0] = 1;
            if (m_c < DEPTH) m_c++;
        end
        exp_q.push_back(snap());
        @(negedge clk);
        active = 1'b1;
        number = IDX_W'(n);
        switches = s;
        @(negedge clk);
        active = inject;
        number = inject ? IDX_W'(2) : IDX_W'($urandom_range(0, 63));
        switches = NSW'($urandom);
        lat = 1;
        check("busy_start", 64'(busy), 64'(1));
        while (!done && lat < 8) begin
            @(negedge clk);
            active = 1'b0;
            lat++;
        end
        check("done_latency", 64'(lat), dup ? 64'(2) : 64'(3));
        x = exp_q.pop_front();
        cmp_snap("capture", x);
        @(negedge clk);
        check("done_single", 64'(done), 64'(0));
        check("busy_end", 64'(busy), 64'(0));
    endtask

    task automatic bad_request(input int n);
        snap_t x;
        x = snap();
        @(negedge clk);
        active = 1'b1;
        number = IDX_W'(n);
        switches = NSW'($urandom);
        @(negedge clk);
        active = 1'b0;
        check("err_pulse", 64'(err), 64'(1));
        check("err_no_done", 64'(done), 64'(0));
        check("err_not_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("err_drop", 64'(err), 64'(0));
        check("err_no_done2", 64'(done), 64'(0));
        cmp_snap("err_hist", x);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        active = 1'b1;
        number = IDX_W'(4);
        @(negedge clk);
        clear = 1'b0;
        active = 1'b0;
        model_clear();
        cmp_snap("clear", snap());
        check("clear_busy", 64'(busy), 64'(0));
        repeat (3) begin
            @(negedge clk);
            check("clear_no_done", 64'(done), 64'(0));
        end
    endtask

    initial begin
        logic [NSW-1:0] s;
        reset = 1'b1;
        active = 1'b0;
        clear = 1'b0;
        number = '0;
        switches = '0;
        model_clear();
        repeat (2) @(negedge clk);
        cmp_snap("reset", snap());
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        reset = 1'b0;

        s = NSW'($urandom) | NSW'(1 << 4);
        request(5, s, 0);
        s = NSW'($urandom) & ~NSW'(1 << 8);
        request(9, s, 0);
        s = NSW'($urandom) & ~NSW'(1 << 2);
        request(3, s, 0);
        check("t1_entry", 64'(entry), 64'({6'd0, 6'd4, 6'd8, 6'd2}));
        check("t1_status", 64'(status), 64'(4'b0100));
        check("t1_valid", 64'(valid), 64'(4'b0111));
        check("t1_count", 64'(count), 64'(3));

        do_clear();

        for (int i = 1; i <= 6; i++) request(i, NSW'($urandom), i == 3);
        check("t2_entry", 64'(entry), 64'({6'd2, 6'd3, 6'd4, 6'd5}));
        check("t2_valid", 64'(valid), 64'(4'b1111));
        check("t2_count", 64'(count), 64'(4));

        bad_request(0);
        bad_request(19);
        request(18, NSW'($urandom), 0);

        do_clear();
        s = NSW'($urandom) | NSW'(1 << 6);
        request(7, s, 0);
        s = s & ~NSW'(1 << 6);
        request(7, s, 0);
        check("t3_status0", 64'(status[0]), 64'(0));
`ifdef HISTORY_DEDUP_EN
        check("t3_count", 64'(count), 64'(1));
`else
        check("t3_count", 64'(count), 64'(2));
`endif

        @(negedge clk);
        active = 1'b1;
        number = IDX_W'(10);
        switches = NSW'($urandom);
        @(negedge clk);
        active = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        model_clear();
        cmp_snap("rst_mid", snap());
        check("rst_mid_busy0", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_done", 64'(done), 64'(0));
        end
        cmp_snap("rst_after", snap());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
